// File: rtl/hpdmc_rdcapture.sv
// hpdmc_rdcapture: DDR read-data capture with CAS-latency delay line, burst window and FWFT output FIFO.
// Ports: sys_clk/sys_rst_n clock and async active-low reset; cas_latency/rd_issue schedule a capture;
// iddr_q0/iddr_q1 IDDR halves; out_data/out_valid/out_ready/out_last FIFO head handshake;
// busy activity flag; overflow/collision sticky errors cleared by err_clr.
module hpdmc_rdcapture #(
  parameter int BURST_WORDS = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [2:0]  cas_latency,
  input  logic        rd_issue,
  input  logic [15:0] iddr_q0,
  input  logic [15:0] iddr_q1,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        overflow,
  output logic        collision,
  input  logic        err_clr
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int NW = $clog2(BURST_WORDS + 1);
  logic [6:0]    r_dly;
  logic [NW-1:0] r_cnt;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_coll;
  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [2:0]    w_lat;
  logic          w_cap, w_win, w_last_tag, w_coll, w_pop, w_full, w_wr, w_ovf;
  logic [NW-1:0] w_rem;
  always_comb begin
    w_lat      = (cas_latency < 3'd2) ? 3'd2 : cas_latency;
    // r_dly[k] holds rd_issue from k+1 cycles ago, so tap L-1 fires L cycles after the issue
    w_cap      = r_dly[w_lat - 3'd1];
    // words remaining in the window including the current cycle
    w_rem      = w_cap ? NW'(BURST_WORDS) : r_cnt;
    w_win      = w_rem != '0;
    w_last_tag = w_rem == NW'(1);
    w_coll     = w_cap & (r_cnt != '0);
    w_pop      = out_valid & out_ready;
    w_full     = r_count == CW'(FIFO_DEPTH);
    // a full FIFO still accepts a push when the head leaves in the same cycle
    w_wr       = w_win & (~w_full | w_pop);
    w_ovf      = w_win & w_full & ~w_pop;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dly   <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      r_dly   <= {r_dly[5:0], rd_issue};
      r_cnt   <= w_win ? w_rem - NW'(1) : '0;
      r_wptr  <= w_wr ? ((r_wptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + AW'(1)) : r_wptr;
      r_rptr  <= w_pop ? ((r_rptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + AW'(1)) : r_rptr;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      // a new error event outranks a simultaneous clear
      r_ovf   <= w_ovf | (r_ovf & ~err_clr);
      r_coll  <= w_coll | (r_coll & ~err_clr);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wptr] <= {w_last_tag, iddr_q1, iddr_q0};
  end
  // storage is not reset, so the head is masked to zero whenever the FIFO is empty
  assign out_valid            = r_count != '0;
  assign {out_last, out_data} = out_valid ? r_mem[r_rptr] : 33'd0;
  assign busy                 = (|r_dly) | (r_cnt != '0) | out_valid;
  assign overflow             = r_ovf;
  assign collision            = r_coll;
endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// tb_hpdmc_rdcapture: scoreboard bench for hpdmc_rdcapture with directed read bursts.
module tb_hpdmc_rdcapture;
  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [2:0]  cas_latency = 3'd2;
  logic        rd_issue = 1'b0;
  logic [15:0] iddr_q0 = 16'h0;
  logic [15:0] iddr_q1 = 16'h0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        overflow;
  logic        collision;
  logic        err_clr = 1'b0;
  exp_t        q_exp[$];
  int          n_checks = 0;
  int          n_fail = 0;
  hpdmc_rdcapture dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cas_latency(cas_latency), .rd_issue(rd_issue),
    .iddr_q0(iddr_q0), .iddr_q1(iddr_q1), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .overflow(overflow),
    .collision(collision), .err_clr(err_clr)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_exp(input logic [31:0] d, input logic l);
    q_exp.push_back('{d: d, l: l});
  endtask
  // scoreboard monitor: compares every accepted head against the next expected word
  always @(negedge sys_clk) begin : mon
    exp_t e;
    if (sys_rst_n && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h last %b expected none", out_data, out_last);
      end else begin
        e = q_exp.pop_front();
        check("word", out_data, e.d);
        check("last", {31'd0, out_last}, {31'd0, e.l});
      end
    end
  end
  // drives cycles k0..k1-1; data in lo..hi counts up from {h0,l0}, junk elsewhere
  task automatic run(input int k0, input int k1, input int i0, input int i1, input int i2,
                     input int lo, input int hi, input logic [15:0] h0, input logic [15:0] l0);
    for (int k = k0; k < k1; k++) begin
      rd_issue = (k == i0) || (k == i1) || (k == i2);
      if (k >= lo && k <= hi) begin
        iddr_q1 = h0 + 16'(k - lo);
        iddr_q0 = l0 + 16'(k - lo);
      end else begin
        iddr_q1 = 16'hDEAD;
        iddr_q0 = 16'hBEEF;
      end
      @(posedge sys_clk);
      #1;
    end
    rd_issue = 1'b0;
    iddr_q1  = 16'hDEAD;
    iddr_q0  = 16'hBEEF;
  endtask
  task automatic drain(input string name);
    for (int c = 0; c < 64 && q_exp.size() != 0; c++) begin
      @(posedge sys_clk);
      #1;
    end
    check({name, "_drained"}, q_exp.size(), 0);
    @(posedge sys_clk);
    #1;
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_valid"}, {31'd0, out_valid}, 0);
  endtask
  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge sys_clk);
    #1;
    err_clr = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", out_data, 0);
    check("rst_flags", {28'd0, out_last, busy, overflow, collision}, 0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    // single read, L=3, issue at cycle 10
    cas_latency = 3'd3;
    push_exp(32'h11110001, 1'b0);
    push_exp(32'h11120002, 1'b0);
    push_exp(32'h11130003, 1'b0);
    push_exp(32'h11140004, 1'b1);
    run(0, 13, 10, -1, -1, 13, 16, 16'h1111, 16'h0001);
    check("t1_valid_c13", {31'd0, out_valid}, 0);
    run(13, 14, 10, -1, -1, 13, 16, 16'h1111, 16'h0001);
    check("t1_valid_c14", {31'd0, out_valid}, 1);
    check("t1_head_c14", out_data, 32'h11110001);
    run(14, 20, 10, -1, -1, 13, 16, 16'h1111, 16'h0001);
    drain("t1");
    // back-to-back, L=2, issues at 0 and 4
    cas_latency = 3'd2;
    for (int i = 0; i < 8; i++) push_exp({16'h2000 + 16'(i), 16'h0000 + 16'(i)}, i == 3 || i == 7);
    run(0, 14, 0, 4, -1, 2, 9, 16'h2000, 16'h0000);
    drain("t2");
    check("t2_collision", {31'd0, collision}, 0);
    // collision, L=2, issues at 0 and 2
    for (int i = 0; i < 6; i++) push_exp({16'h3000 + 16'(i), 16'h0100 + 16'(i)}, i == 5);
    run(0, 12, 0, 2, -1, 2, 7, 16'h3000, 16'h0100);
    drain("t3");
    check("t3_collision", {31'd0, collision}, 1);
    check("t3_overflow", {31'd0, overflow}, 0);
    pulse_clr();
    check("t3_collision_clr", {31'd0, collision}, 0);
    // backpressure: 12 words into an 8-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_exp({16'h4000 + 16'(i), 16'h0000 + 16'(i)}, i == 3 || i == 7);
    run(0, 16, 0, 4, 8, 2, 13, 16'h4000, 16'h0000);
    check("t4_overflow", {31'd0, overflow}, 1);
    check("t4_valid", {31'd0, out_valid}, 1);
    check("t4_head", out_data, 32'h40000000);
    check("t4_busy", {31'd0, busy}, 1);
    run(0, 3, -1, -1, -1, 100, 99, 16'h0, 16'h0);
    check("t4_head_stable", out_data, 32'h40000000);
    out_ready = 1'b1;
    drain("t4");
    pulse_clr();
    check("t4_overflow_clr", {31'd0, overflow}, 0);
    // latency clamp: 0 and 1 behave as 2
    cas_latency = 3'd0;
    for (int i = 0; i < 4; i++) push_exp({16'h5000 + 16'(i), 16'h0000 + 16'(i)}, i == 3);
    run(0, 10, 0, -1, -1, 2, 5, 16'h5000, 16'h0000);
    drain("t5a");
    cas_latency = 3'd1;
    for (int i = 0; i < 4; i++) push_exp({16'h5100 + 16'(i), 16'h0010 + 16'(i)}, i == 3);
    run(0, 10, 0, -1, -1, 2, 5, 16'h5100, 16'h0010);
    drain("t5b");
    // reset at the second capture cycle discards everything
    cas_latency = 3'd2;
    run(0, 3, 0, -1, -1, 2, 5, 16'h6000, 16'h0000);
    sys_rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, out_valid}, 0);
    check("t6_data", out_data, 0);
    check("t6_flags", {28'd0, out_last, busy, overflow, collision}, 0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    run(0, 10, -1, -1, -1, 100, 99, 16'h0, 16'h0);
    check("t6_valid_after", {31'd0, out_valid}, 0);
    check("t6_busy_after", {31'd0, busy}, 0);
    check("t6_queue", q_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
